// File: rtl/block_transfer_sequencer_if.sv
// Memory beat handshake between the block transfer sequencer and the data memory port.
interface block_transfer_sequencer_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  mem_req;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_write;
  logic                  mem_ack;
  logic                  mem_abort;

  modport master (
    output mem_req,
    output mem_addr,
    output mem_write,
    input  mem_ack,
    input  mem_abort
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    input  mem_write,
    output mem_ack,
    output mem_abort
  );
endinterface

// File: rtl/block_transfer_sequencer.sv
// LDM/STM sequencer: one register per memory beat, ascending order, optional base writeback.
// Define EMPTY_LIST_QUIRK_EN for ARMv4 empty-list behaviour (single R15 beat, base +/- 0x40).
module block_transfer_sequencer #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [27:0]                   instruction,
  input  logic [ADDR_WIDTH-1:0]         base_value,
  block_transfer_sequencer_if.master    mem,
  output logic                          busy,
  output logic [3:0]                    reg_addr,
  output logic                          reg_we,
  output logic                          writeback_en,
  output logic [3:0]                    writeback_addr,
  output logic [ADDR_WIDTH-1:0]         writeback_value,
  output logic                          done,
  output logic                          aborted
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_XFER,
    S_WB,
    S_DONE
  } state_t;

  state_t                state_q, state_d;

  logic                  p_q, u_q, w_q, l_q;
  logic [3:0]            rn_q;
  logic [15:0]           list_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] wb_value_q;
  logic                  rn_in_list_q;
  logic                  aborted_q;

  // Opcode and S bits carry no information for this sequencer.
  logic unused_instr_bits;
  assign unused_instr_bits = ^{instruction[27:25], instruction[22]};

  // SETUP arithmetic: transfer count, span in bytes, first beat address, writeback value.
  logic [4:0]            n;
  logic [15:0]           eff_list;
  logic [ADDR_WIDTH-1:0] span;
  logic [ADDR_WIDTH-1:0] first_addr;
  logic [ADDR_WIDTH-1:0] wb_value;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
    n = '0;
    for (int i = 0; i < 16; i++) begin
      n = n + 5'(list_q[i]);
    end
    eff_list = list_q;
    span     = ADDR_WIDTH'(n) << 2;
`ifdef EMPTY_LIST_QUIRK_EN
    if (list_q == 16'h0000) begin
      eff_list = 16'h8000;
      span     = ADDR_WIDTH'(64);
    end
`endif
    unique case ({p_q, u_q})
      2'b01:   first_addr = base_q;
      2'b11:   first_addr = base_q + ADDR_WIDTH'(4);
      2'b00:   first_addr = base_q - span + ADDR_WIDTH'(4);
      default: first_addr = base_q - span;
    endcase
    wb_value = u_q ? (base_q + span) : (base_q - span);
  end

  // Lowest remaining register and the list left once it has been transferred.
  logic [3:0]  low_idx;
  logic [15:0] list_next;
  logic        last_beat;

  always_comb begin
    low_idx = '0;
    for (int i = 15; i >= 0; i--) begin
      if (list_q[i]) low_idx = 4'(i);
    end
    list_next = list_q & (list_q - 16'd1);
    last_beat = (list_next == 16'h0000);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from the same pre-edge values.
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    busy          = 1'b1;
    reg_addr      = '0;
    mem.mem_req   = 1'b0;
    mem.mem_addr  = '0;
    mem.mem_write = 1'b0;
    writeback_en  = 1'b0;
    done          = 1'b0;
    aborted       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_d = S_SETUP;
      end
      S_SETUP: begin
        state_d = (eff_list == 16'h0000) ? S_DONE : S_XFER;
      end
      S_XFER: begin
        reg_addr      = low_idx;
        mem.mem_req   = 1'b1;
        mem.mem_addr  = addr_q;
        mem.mem_write = ~l_q;
        if (mem.mem_ack) begin
          if (mem.mem_abort)  state_d = S_DONE;
          else if (last_beat) state_d = w_q ? S_WB : S_DONE;
        end
      end
      S_WB: begin
        // A loaded base register keeps the loaded value.
        writeback_en = ~(l_q & rn_in_list_q);
        state_d      = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        aborted = aborted_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign reg_we          = mem.mem_req & mem.mem_ack & l_q & ~mem.mem_abort;
  assign writeback_addr  = rn_q;
  assign writeback_value = wb_value_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      p_q          <= 1'b0;
      u_q          <= 1'b0;
      w_q          <= 1'b0;
      l_q          <= 1'b0;
      rn_q         <= '0;
      list_q       <= '0;
      base_q       <= '0;
      addr_q       <= '0;
      wb_value_q   <= '0;
      rn_in_list_q <= 1'b0;
      aborted_q    <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            p_q       <= instruction[24];
            u_q       <= instruction[23];
            w_q       <= instruction[21];
            l_q       <= instruction[20];
            rn_q      <= instruction[19:16];
            list_q    <= instruction[15:0];
            base_q    <= base_value;
            aborted_q <= 1'b0;
          end
        end
        S_SETUP: begin
          addr_q       <= first_addr;
          wb_value_q   <= wb_value;
          list_q       <= eff_list;
          rn_in_list_q <= eff_list[rn_q];
        end
        S_XFER: begin
          if (mem.mem_ack) begin
            if (mem.mem_abort) begin
              aborted_q <= 1'b1;
            end else begin
              list_q <= list_next;
              addr_q <= addr_q + ADDR_WIDTH'(4);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_block_transfer_sequencer.sv
// Directed bench for block_transfer_sequencer; honours EMPTY_LIST_QUIRK_EN like the RTL.
module tb_block_transfer_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [27:0] instruction;
  logic [31:0] base_value;
  logic        busy;
  logic [3:0]  reg_addr;
  logic        reg_we;
  logic        writeback_en;
  logic [3:0]  writeback_addr;
  logic [31:0] writeback_value;
  logic        done;
  logic        aborted;

  int errors = 0;
  int checks = 0;

  block_transfer_sequencer_if #(.ADDR_WIDTH(32)) mem_bus ();

  block_transfer_sequencer #(.ADDR_WIDTH(32)) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .instruction     (instruction),
    .base_value      (base_value),
    .mem             (mem_bus.master),
    .busy            (busy),
    .reg_addr        (reg_addr),
    .reg_we          (reg_we),
    .writeback_en    (writeback_en),
    .writeback_addr  (writeback_addr),
    .writeback_value (writeback_value),
    .done            (done),
    .aborted         (aborted)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [27:0] mk(input logic p, input logic u, input logic w, input logic l,
                                     input logic [3:0] rn, input logic [15:0] list);
    return {3'b100, p, u, 1'b0, w, l, rn, list};
  endfunction

  task automatic launch(input logic [27:0] instr, input logic [31:0] base);
    start       = 1'b1;
    instruction = instr;
    base_value  = base;
    tick();
    start       = 1'b0;
  endtask

  task automatic beat(input string tag, input logic [3:0] r, input logic [31:0] a, input logic wr);
    check({tag, " req"}, 32'(mem_bus.mem_req), 32'd1);
    check({tag, " reg"}, 32'(reg_addr), 32'(r));
    check({tag, " addr"}, mem_bus.mem_addr, a);
    check({tag, " write"}, 32'(mem_bus.mem_write), 32'(wr));
  endtask

  initial begin
    reset             = 1'b1;
    start             = 1'b0;
    instruction       = '0;
    base_value        = '0;
    mem_bus.mem_ack   = 1'b0;
    mem_bus.mem_abort = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check("rst busy", 32'(busy), 32'd0);
    check("rst req", 32'(mem_bus.mem_req), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst reg_addr", 32'(reg_addr), 32'd0);
    check("rst wb_en", 32'(writeback_en), 32'd0);

    // STMDB W=1 Rn=3 base 0x03001000 list {R4,R5,R6,R14}, ack every cycle.
    mem_bus.mem_ack = 1'b1;
    launch(mk(1, 0, 1, 0, 4'd3, 16'h4070), 32'h0300_1000);
    check("stmdb setup busy", 32'(busy), 32'd1);
    check("stmdb setup req", 32'(mem_bus.mem_req), 32'd0);
    tick(); beat("stmdb b0", 4'd4, 32'h0300_0FF0, 1'b1);
    check("stmdb b0 we", 32'(reg_we), 32'd0);
    tick(); beat("stmdb b1", 4'd5, 32'h0300_0FF4, 1'b1);
    tick(); beat("stmdb b2", 4'd6, 32'h0300_0FF8, 1'b1);
    tick(); beat("stmdb b3", 4'd14, 32'h0300_0FFC, 1'b1);
    tick();
    check("stmdb wb_en", 32'(writeback_en), 32'd1);
    check("stmdb wb_val", writeback_value, 32'h0300_0FF0);
    check("stmdb wb_addr", 32'(writeback_addr), 32'd3);
    check("stmdb wb req", 32'(mem_bus.mem_req), 32'd0);
    tick();
    check("stmdb done", 32'(done), 32'd1);
    check("stmdb aborted", 32'(aborted), 32'd0);
    check("stmdb done busy", 32'(busy), 32'd1);
    mem_bus.mem_ack = 1'b0;
    tick();
    check("stmdb idle busy", 32'(busy), 32'd0);
    check("stmdb idle done", 32'(done), 32'd0);

    // LDMIA W=1 Rn=4 base 0x100 list {R0,R15}, two wait cycles per beat.
    launch(mk(0, 1, 1, 1, 4'd4, 16'h8001), 32'h0000_0100);
    tick(); beat("ldmia b0 w1", 4'd0, 32'h0000_0100, 1'b0);
    check("ldmia b0 w1 we", 32'(reg_we), 32'd0);
    tick(); beat("ldmia b0 w2", 4'd0, 32'h0000_0100, 1'b0);
    tick(); mem_bus.mem_ack = 1'b1; #1;
    beat("ldmia b0 ack", 4'd0, 32'h0000_0100, 1'b0);
    check("ldmia b0 we", 32'(reg_we), 32'd1);
    tick(); mem_bus.mem_ack = 1'b0; #1;
    beat("ldmia b1 w1", 4'd15, 32'h0000_0104, 1'b0);
    check("ldmia b1 w1 we", 32'(reg_we), 32'd0);
    tick(); beat("ldmia b1 w2", 4'd15, 32'h0000_0104, 1'b0);
    tick(); mem_bus.mem_ack = 1'b1; #1;
    check("ldmia b1 we", 32'(reg_we), 32'd1);
    check("ldmia b1 reg", 32'(reg_addr), 32'd15);
    tick(); mem_bus.mem_ack = 1'b0; #1;
    check("ldmia wb_en", 32'(writeback_en), 32'd1);
    check("ldmia wb_val", writeback_value, 32'h0000_0108);
    check("ldmia wb we", 32'(reg_we), 32'd0);
    tick();
    check("ldmia done", 32'(done), 32'd1);
    tick();

    // LDMIB W=1 Rn=2 base 0x200 list {R1,R2}: base is loaded, so no writeback strobe.
    mem_bus.mem_ack = 1'b1;
    launch(mk(1, 1, 1, 1, 4'd2, 16'h0006), 32'h0000_0200);
    tick(); beat("ldmib b0", 4'd1, 32'h0000_0204, 1'b0);
    tick(); beat("ldmib b1", 4'd2, 32'h0000_0208, 1'b0);
    tick();
    check("ldmib wb busy", 32'(busy), 32'd1);
    check("ldmib wb_en", 32'(writeback_en), 32'd0);
    check("ldmib wb done", 32'(done), 32'd0);
    tick();
    check("ldmib done", 32'(done), 32'd1);
    tick();

    // STMIA W=1 list R0..R3, abort on the second beat.
    launch(mk(0, 1, 1, 0, 4'd5, 16'h000F), 32'h0000_0400);
    tick(); beat("abt b0", 4'd0, 32'h0000_0400, 1'b1);
    tick(); mem_bus.mem_abort = 1'b1; #1;
    beat("abt b1", 4'd1, 32'h0000_0404, 1'b1);
    tick(); mem_bus.mem_abort = 1'b0; mem_bus.mem_ack = 1'b0; #1;
    check("abt no b2", 32'(mem_bus.mem_req), 32'd0);
    check("abt wb_en", 32'(writeback_en), 32'd0);
    check("abt done", 32'(done), 32'd1);
    check("abt aborted", 32'(aborted), 32'd1);
    tick();
    check("abt idle", 32'(busy), 32'd0);
    check("abt idle aborted", 32'(aborted), 32'd0);

    // Empty list, IA W=1 base 0x1000.
    mem_bus.mem_ack = 1'b1;
    launch(mk(0, 1, 1, 0, 4'd6, 16'h0000), 32'h0000_1000);
    check("empty setup req", 32'(mem_bus.mem_req), 32'd0);
`ifdef EMPTY_LIST_QUIRK_EN
    tick(); beat("empty b0", 4'd15, 32'h0000_1000, 1'b1);
    tick();
    check("empty wb_en", 32'(writeback_en), 32'd1);
    check("empty wb_val", writeback_value, 32'h0000_1040);
    tick();
    check("empty done", 32'(done), 32'd1);
`else
    tick();
    check("empty done", 32'(done), 32'd1);
    check("empty req", 32'(mem_bus.mem_req), 32'd0);
    check("empty wb_en", 32'(writeback_en), 32'd0);
    check("empty aborted", 32'(aborted), 32'd0);
`endif
    tick();
    check("empty idle", 32'(busy), 32'd0);

    // Reset mid-XFER, then a stray start during a fresh sequence.
    mem_bus.mem_ack = 1'b0;
    launch(mk(0, 1, 1, 0, 4'd7, 16'h00F0), 32'h0000_0800);
    tick(); beat("rx b0", 4'd4, 32'h0000_0800, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rx busy", 32'(busy), 32'd0);
    check("rx req", 32'(mem_bus.mem_req), 32'd0);
    check("rx addr", mem_bus.mem_addr, 32'd0);
    check("rx reg", 32'(reg_addr), 32'd0);
    check("rx wb_val", writeback_value, 32'd0);
    check("rx wb_addr", 32'(writeback_addr), 32'd0);
    check("rx done", 32'(done), 32'd0);
    tick();
    check("rx no wb", 32'(writeback_en), 32'd0);
    check("rx no done", 32'(done), 32'd0);

    mem_bus.mem_ack = 1'b1;
    launch(mk(0, 1, 0, 0, 4'd8, 16'h0003), 32'h0000_0900);
    tick();
    start       = 1'b1;
    instruction = mk(0, 1, 1, 0, 4'd9, 16'hFFFF);
    base_value  = 32'h0000_5000;
    #1;
    beat("stray b0", 4'd0, 32'h0000_0900, 1'b1);
    tick();
    start = 1'b0;
    beat("stray b1", 4'd1, 32'h0000_0904, 1'b1);
    tick();
    check("stray done", 32'(done), 32'd1);
    mem_bus.mem_ack = 1'b0;
    tick();
    check("stray idle busy", 32'(busy), 32'd0);
    tick();
    check("stray no restart", 32'(busy), 32'd0);
    check("stray no done", 32'(done), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/block_transfer_sequencer.md
Name: block_transfer_sequencer

Overview:
Multi-cycle controller for ARM LDM/STM (block data transfer) instructions. Walks the 16-bit register list one register per memory beat, driving the register-file port address, the memory address/request handshake, load write-enables, and the final base writeback. Sits between the decode stage, which supplies the instruction and the base-register value read via Rn, and the register file / memory interface. Runs while the pipeline is stalled on busy.

Parameters:
ADDR_WIDTH, 32, width of base_value, mem_addr and writeback_value.

Ports:
clk  input  1  core clock; all state changes on rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  launch the sequence; sampled only in IDLE.
instruction  input  28  bits [27:0] of the LDM/STM word: [24] P, [23] U, [22] S (ignored), [21] W, [20] L, [19:16] Rn, [15:0] register list; sampled with start.
base_value  input  ADDR_WIDTH  current Rn contents; sampled with start.
mem_ack  input  1  memory has completed the current beat.
mem_abort  input  1  data abort for the current beat; valid only with mem_ack.
busy  output  1  high in every state except IDLE.
reg_addr  output  4  register-file address for the current beat; 0 when not in XFER.
mem_addr  output  ADDR_WIDTH  word address of the current beat.
mem_req  output  1  beat request; high throughout XFER.
mem_write  output  1  equals latched ~L while in XFER; 0 otherwise.
reg_we  output  1  load write-enable: mem_req & mem_ack & L & ~mem_abort.
writeback_en  output  1  one-cycle base writeback strobe.
writeback_addr  output  4  latched Rn.
writeback_value  output  ADDR_WIDTH  updated base value.
done  output  1  one-cycle completion pulse.
aborted  output  1  valid with done: the sequence ended on mem_abort.

Behaviour:
- Reset: state IDLE. All outputs 0; internal list, count and address registers cleared. A reset in any state abandons the sequence with no writeback and no done pulse.
- IDLE: if start, latch instruction and base_value, go to SETUP. start while busy is ignored.
- SETUP (1 cycle):
  - n = popcount(list).
  - First address is one of:
    - IA (P=0, U=1): base.
    - IB (P=1, U=1): base+4.
    - DA (P=0, U=0): base-4n+4.
    - DB (P=1, U=0): base-4n.
  - Writeback value: U ? base+4n : base-4n. All arithmetic is modulo 2^ADDR_WIDTH.
  - If n = 0, go to DONE (see optional feature); otherwise go to XFER.
- XFER:
  - reg_addr = index of the lowest set bit of the remaining list. Registers always go in ascending order at ascending addresses.
  - mem_req is held, and mem_addr and reg_addr are stable, until mem_ack.
  - On mem_ack with mem_abort: go to DONE with aborted=1. No writeback.
  - On mem_ack without abort: clear the bit and add 4 to the address. If that was the last bit, go to WB when W=1, else go to DONE. Otherwise stay in XFER; the next beat is presented the following cycle, with no idle gap.
- WB (1 cycle): writeback_en=1. If L=1 and Rn is in the list, writeback_en is suppressed (the loaded value wins).
- DONE (1 cycle): done=1, then go to IDLE. busy falls in the IDLE cycle.
- Latency: for one register, W=0 and mem_ack in the first XFER cycle, start is at cycle 0, SETUP at 1, XFER at 2, DONE at 3, IDLE at 4. Total = 3 + beats + stall cycles + W.

Optional Feature:
Macro EMPTY_LIST_QUIRK_EN.
- Defined: an empty list behaves as ARMv4 hardware does. One beat transfers R15 at the first address computed with n=16. Writeback value is base±0x40.
- Undefined: an empty list goes SETUP→DONE with no beats, no writeback and aborted=0.

Test Plan:
- STMDB W=1, base 0x03001000, list 0x4070, mem_ack every cycle → reg_addr 4,5,6,14 at mem_addr 0x03000FF0/FF4/FF8/FFC with mem_write=1; writeback_value 0x03000FF0; done 7 cycles after start.
- LDMIA W=1, base 0x00000100, list 0x8001, mem_ack delayed 2 cycles per beat → beats R0@0x100 and R15@0x104, each held stable until ack; reg_we one cycle per ack; writeback 0x108.
- LDMIB W=1, Rn=2, list 0x0006, base 0x200 → beats at 0x204 and 0x208; writeback_en stays 0 because R2 was loaded.
- STMIA, list 0x000F, mem_abort on the 2nd beat → no 3rd beat, writeback_en never asserts, done=1 and aborted=1.
- Empty list, base 0x1000, U=1, W=1 → macro undefined: done 2 cycles after start, no mem_req. Macro defined: one beat with R15@0x1000, writeback 0x1040.
- Reset asserted in XFER mid-list, then start pulsed during busy on a fresh sequence → all outputs 0 the cycle after reset; the stray start is ignored, with no restart or double done.
